encoder4to2_pipe: RTL

- Registered priority encoder; the inverse of the team's 2-to-4 decoder.
- Accepts an N-bit request vector over a valid/ready handshake and returns the index of the highest set bit, plus none/multi-hot flags, one cycle later.
- Sits between one-hot request sources (grant/select lines) and logic that needs a binary index, e.g. feeding a downstream decoder.

---
 rtl/enc_pkg.sv | 17 +
 rtl/prio_enc_core.sv | 26 ++
 rtl/encoder4to2_pipe.sv | 86 ++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared constants and index-width helper for the priority encoder family.
package enc_pkg;

    localparam int ENC_N_DEFAULT = 4;
    localparam int ERR_CNT_W     = 8;

    // Smallest w with 2**w >= n, never less than 1 so an index port always exists.
    function automatic int idx_w(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational MSB-priority encoder: index of the highest set bit plus none/multi-hot flags.
module prio_enc_core
    import enc_pkg::*;
#(
    parameter  int N = ENC_N_DEFAULT,
    localparam int W = idx_w(N)
) (
    input  logic [N-1:0] d,
    output logic [W-1:0] idx,
    output logic         none,
    output logic         multi
);

    // Ascending scan so the last hit (highest bit) wins.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (d[i]) idx = W'(i);
        end
    end

    assign none = (d == '0);
    // Clearing the lowest set bit leaves something only if more than one bit was set.
    assign multi = |(d & (d - N'(1)));

endmodule

// File: rtl/encoder4to2_pipe.sv
// Registered priority encoder with valid/ready handshake and one output register stage.
// Optional multi-hot error counter enabled by defining ENC_ERR_CNT_EN.
module encoder4to2_pipe
    import enc_pkg::*;
#(
    parameter  int N = ENC_N_DEFAULT,
    localparam int W = idx_w(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 e,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         d,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_idx,
    output logic                 out_none,
    output logic                 out_multi,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [W-1:0] idx_p0;
    logic         none_p0;
    logic         multi_p0;
    logic         accept_p0;

    logic [W-1:0] idx_p1;
    logic         none_p1;
    logic         multi_p1;
    logic         vld_p1;

    prio_enc_core #(.N(N)) u_core (
        .d     (d),
        .idx   (idx_p0),
        .none  (none_p0),
        .multi (multi_p0)
    );

    // A draining slot can be refilled in the same cycle, giving full throughput.
    assign in_ready  = e && (!vld_p1 || out_ready);
    assign accept_p0 = in_valid && in_ready;

    // ---- stage p0 -> p1 boundary: output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            idx_p1   <= '0;
            none_p1  <= 1'b0;
            multi_p1 <= 1'b0;
        end else if (accept_p0) begin
            vld_p1   <= 1'b1;
            idx_p1   <= idx_p0;
            none_p1  <= none_p0;
            multi_p1 <= multi_p0;
        end else if (out_ready) begin
            vld_p1   <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_idx   = idx_p1;
    assign out_none  = none_p1;
    assign out_multi = multi_p1;

`ifdef ENC_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_p1;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_p1 <= '0;
        end else if (accept_p0 && multi_p0) begin
            err_cnt_p1 <= sat_inc(err_cnt_p1);
        end
    end

    assign err_cnt = err_cnt_p1;
`else
    assign err_cnt = '0;
`endif

endmodule
